// File: rtl/iu_chk.sv
// iu_chk: checks predicted PCs against the executed trace PC.
//
// A trace PC is accepted in FETCH and held in WAIT. The next prediction strobe is compared
// against it: a hit returns to FETCH; a miss passes through RESP, where a one-cycle registered
// miss pulse is raised and pc_curr carries the actual PC. If no prediction arrives within
// TIMEOUT WAIT cycles, the held PC is dropped and timeout_err is set. A prediction that arrives
// while no trace PC is held sets overrun_err and is otherwise ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_pre, pc_pre_oe   predicted PC and its one-cycle strobe
//   trace_pc            executed PC from the trace source
//   trace_valid         trace_pc is valid
//   trace_ready         trace_pc is accepted this cycle
//   miss                registered one-cycle mispredict pulse
//   pc_curr             actual PC of the last mispredicted slot
//   timeout_err         sticky WAIT-expiry flag
//   overrun_err         sticky prediction-without-trace flag
//   hit_cnt, miss_cnt   saturating hit/miss counters
//
// Build option: define IU_CHK_STATS_EN to enable hit_cnt/miss_cnt. Without it both are tied to 0.

module iu_chk #(
  parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_pre,
  input  logic        pc_pre_oe,
  input  logic [63:0] trace_pc,
  input  logic        trace_valid,
  output logic        trace_ready,
  output logic        miss,
  output logic [63:0] pc_curr,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  typedef enum logic [1:0] {StFetch, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [63:0] act_pc_q, act_pc_d;
  logic [63:0] pc_curr_q, pc_curr_d;
  logic        miss_q, miss_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;

  logic in_wait;
  logic pred_hit;
  logic pred_miss;
  logic expire;

  assign in_wait   = (state_q == StWait);
  assign pred_hit  = in_wait && pc_pre_oe && (pc_pre == act_pc_q);
  assign pred_miss = in_wait && pc_pre_oe && (pc_pre != act_pc_q);
  // Expiry fires on the WAIT cycle whose increment would reach TIMEOUT, so WAIT lasts at most
  // TIMEOUT cycles; a strobe on that same cycle is compared instead.
  assign expire    = in_wait && !pc_pre_oe && (wait_q == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (trace_valid) state_d = StWait;
      StWait: begin
        if (pred_hit || expire) begin
          state_d = StFetch;
        end else if (pred_miss) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output logic: ready is state-decoded and held low while reset is asserted.
  always_comb begin
    trace_ready = rst_n && (state_q == StFetch);
  end

  // Datapath next-state
  always_comb begin
    act_pc_d  = act_pc_q;
    wait_d    = wait_q;
    pc_curr_d = pc_curr_q;
    miss_d    = pred_miss;
    timeout_d = timeout_q | expire;
    overrun_d = overrun_q | (pc_pre_oe && !in_wait);

    if (state_q == StFetch && trace_valid) begin
      act_pc_d = trace_pc;
      wait_d   = 8'd0;
    end else if (in_wait && !pc_pre_oe) begin
      wait_d = wait_q + 8'd1;
    end

    if (expire) begin
      act_pc_d = 64'd0;
    end

    if (pred_miss) begin
      pc_curr_d = act_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pc_q  <= 64'd0;
      wait_q    <= 8'd0;
      pc_curr_q <= 64'd0;
      miss_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      act_pc_q  <= act_pc_d;
      wait_q    <= wait_d;
      pc_curr_q <= pc_curr_d;
      miss_q    <= miss_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign miss        = miss_q;
  assign pc_curr     = pc_curr_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;

`ifdef IU_CHK_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (pred_hit && hit_cnt_q != 32'hFFFF_FFFF) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (pred_miss && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_iu_chk.sv
// Self-checking bench for iu_chk: directed scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level reference model.

module tb_iu_chk;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_pre;
  logic        pc_pre_oe;
  logic [63:0] trace_pc;
  logic        trace_valid;
  logic        trace_ready;
  logic        miss;
  logic [63:0] pc_curr;
  logic        timeout_err;
  logic        overrun_err;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  iu_chk #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_pre     (pc_pre),
    .pc_pre_oe  (pc_pre_oe),
    .trace_pc   (trace_pc),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .miss       (miss),
    .pc_curr    (pc_curr),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: at most one held trace PC, its age in WAIT cycles, and whether the cycle
  // after the last edge is the mispredict-report slot.
  bit          m_held;
  logic [63:0] m_hpc;
  int unsigned m_age;
  bit          m_resp;
  logic [63:0] m_pc_curr;
  bit          m_timeout;
  bit          m_overrun;
  longint unsigned m_hits;
  longint unsigned m_misses;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] stat(input longint unsigned n);
`ifdef IU_CHK_STATS_EN
    return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
`else
    return (n == n) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_held = 0; m_hpc = '0; m_age = 0; m_resp = 0; m_pc_curr = '0;
    m_timeout = 0; m_overrun = 0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_edge(input bit tv, input logic [63:0] tpc, input bit oe,
                            input logic [63:0] ppc);
    if (oe && !m_held) m_overrun = 1;
    if (m_resp) begin
      m_resp = 0;
    end else if (!m_held) begin
      if (tv) begin
        m_held = 1; m_hpc = tpc; m_age = 0;
      end
    end else if (oe) begin
      if (ppc == m_hpc) begin
        m_hits++;
      end else begin
        m_misses++;
        m_pc_curr = m_hpc;
        m_resp = 1;
      end
      m_held = 0;
    end else begin
      m_age++;
      if (m_age == TIMEOUT) begin
        m_timeout = 1;
        m_held = 0;
      end
    end
  endtask

  task automatic check_all();
    check("trace_ready", 64'(trace_ready), 64'(!m_held && !m_resp));
    check("miss", 64'(miss), 64'(m_resp));
    check("pc_curr", pc_curr, m_pc_curr);
    check("timeout_err", 64'(timeout_err), 64'(m_timeout));
    check("overrun_err", 64'(overrun_err), 64'(m_overrun));
    check("hit_cnt", 64'(hit_cnt), 64'(stat(m_hits)));
    check("miss_cnt", 64'(miss_cnt), 64'(stat(m_misses)));
  endtask

  task automatic step(input bit tv, input logic [63:0] tpc, input bit oe,
                      input logic [63:0] ppc);
    trace_valid = tv; trace_pc = tpc; pc_pre_oe = oe; pc_pre = ppc;
    @(posedge clk);
    model_edge(tv, tpc, oe, ppc);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 64'd0, 0, 64'd0);
  endtask

  initial begin
    logic [63:0] rpc;
    logic [63:0] ppc;
    bit tv;
    bit oe;

    rst_n = 0; trace_valid = 0; trace_pc = '0; pc_pre_oe = 0; pc_pre = '0;
    model_reset();
    #12;
    check("reset_ready", 64'(trace_ready), 64'd0);
    check("reset_miss", 64'(miss), 64'd0);
    check("reset_pc_curr", pc_curr, 64'd0);
    check("reset_errs", 64'({timeout_err, overrun_err}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 check("ready_after_reset", 64'(trace_ready), 64'd1);

    // Hit three cycles after capture
    step(1, 64'h1000, 0, 64'd0);
    idle(2);
    step(0, 64'd0, 1, 64'h1000);
    check("hit_no_miss", 64'(miss), 64'd0);
    check("hit_ready", 64'(trace_ready), 64'd1);

    // Mispredict
    step(1, 64'h2000, 0, 64'd0);
    step(0, 64'd0, 1, 64'h2004);
    check("miss_pulse", 64'(miss), 64'd1);
    check("miss_pc_curr", pc_curr, 64'h2000);
    idle(1);
    check("miss_one_cycle", 64'(miss), 64'd0);

    // Timeout, then a strobe on the last allowed cycle is compared instead
    step(1, 64'h3000, 0, 64'd0);
    idle(TIMEOUT);
    check("timeout_set", 64'(timeout_err), 64'd1);
    check("timeout_ready", 64'(trace_ready), 64'd1);
    step(1, 64'h3100, 0, 64'd0);
    idle(TIMEOUT - 1);
    step(0, 64'd0, 1, 64'h3104);
    check("late_strobe_miss", 64'(miss), 64'd1);

    // Overrun in RESP, then in FETCH
    step(0, 64'd0, 1, 64'h5555);
    check("overrun_resp", 64'(overrun_err), 64'd1);
    step(0, 64'd0, 1, 64'h7777);

    // Reset during RESP
    step(1, 64'h4000, 0, 64'd0);
    step(0, 64'd0, 1, 64'h4008);
    check("pre_reset_miss", 64'(miss), 64'd1);
    #1 rst_n = 0;
    #1;
    check("rst_resp_miss", 64'(miss), 64'd0);
    check("rst_resp_pc_curr", pc_curr, 64'd0);
    check("rst_resp_cnt", 64'({hit_cnt, miss_cnt}), 64'd0);
    check("rst_resp_ready", 64'(trace_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    #1 check("rst_release_ready", 64'(trace_ready), 64'd1);
    step(1, 64'h4100, 0, 64'd0);
    step(0, 64'd0, 1, 64'h4100);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tv  = ($urandom_range(0, 3) != 0);
      rpc = {$urandom(), $urandom()};
      oe  = ($urandom_range(0, 19) == 0);
      if (m_held && $urandom_range(0, 1) == 1) ppc = m_hpc;
      else ppc = {$urandom(), $urandom()};
      step(tv, rpc, oe, ppc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
